// File: rtl/commit_trace_sequencer.sv
// Collects up to two retirements plus one exception per cycle into a small FIFO and emits them
// as sequence-numbered trace records. Optional saturating drop counter: COMMIT_TRACE_LOST_CNT_EN.
module commit_trace_sequencer #(
  parameter int DEPTH = 8,
  parameter int VLEN  = 64,
  parameter int XLEN  = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic [1:0]           commit_valid_i,
  input  logic [1:0][VLEN-1:0] commit_pc_i,
  input  logic [1:0][31:0]     commit_instr_i,
  input  logic [1:0][4:0]      commit_rd_i,
  input  logic [1:0][XLEN-1:0] commit_wdata_i,
  input  logic [1:0]           priv_lvl_i,
  input  logic                 exc_valid_i,
  input  logic [XLEN-1:0]      exc_cause_i,
  input  logic [XLEN-1:0]      exc_tval_i,
  output logic                 trace_valid_o,
  input  logic                 trace_ready_i,
  output logic                 trace_kind_o,
  output logic [VLEN-1:0]      trace_pc_o,
  output logic [31:0]          trace_instr_o,
  output logic [4:0]           trace_rd_o,
  output logic [XLEN-1:0]      trace_data_o,
  output logic [XLEN-1:0]      trace_tval_o,
  output logic [1:0]           trace_priv_o,
  output logic [15:0]          trace_seq_o,
  output logic                 lost_o
`ifdef COMMIT_TRACE_LOST_CNT_EN
  ,
  output logic [15:0]          lost_cnt_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic            kind;
    logic [VLEN-1:0] pc;
    logic [31:0]     instr;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
    logic [XLEN-1:0] tval;
    logic [1:0]      priv;
    logic [15:0]     seq;
  } rec_t;

  rec_t          mem_q [DEPTH];
  rec_t          mem_d [DEPTH];
  rec_t          offer [4];
  rec_t          head;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] space;
  logic [15:0]   seq_q, seq_d;
  logic          lost_q, lost_d;
  logic [1:0]    n_off;
  logic [1:0]    wr_num;
  logic          fits;
  logic          drop;
  logic          pop;

  // Compact this cycle's offered records into slots 0..n_off-1 in port0, port1, exception order.
  always_comb begin
    n_off = '0;
    for (int k = 0; k < 4; k++) offer[k] = '0;
    if (enable_i) begin
      for (int p = 0; p < 2; p++) begin
        if (commit_valid_i[p]) begin
          offer[n_off] = '{kind: 1'b0, pc: commit_pc_i[p], instr: commit_instr_i[p],
                           rd: commit_rd_i[p], data: commit_wdata_i[p], tval: '0,
                           priv: priv_lvl_i, seq: seq_q + 16'(n_off)};
          n_off = n_off + 2'd1;
        end
      end
      if (exc_valid_i) begin
        offer[n_off] = '{kind: 1'b1, pc: commit_pc_i[0], instr: '0, rd: '0,
                         data: exc_cause_i, tval: exc_tval_i,
                         priv: priv_lvl_i, seq: seq_q + 16'(n_off)};
        n_off = n_off + 2'd1;
      end
    end
  end

  // Admission is all-or-nothing against pre-pop occupancy.
  always_comb begin
    space  = CW'(DEPTH) - count_q;
    fits   = CW'(n_off) <= space;
    wr_num = fits ? n_off : 2'd0;
    drop   = (n_off != 2'd0) && !fits;
    pop    = (count_q != '0) && trace_ready_i;

    mem_d = mem_q;
    for (int k = 0; k < 3; k++) begin
      if (2'(k) < wr_num) mem_d[wr_ptr_q + AW'(k)] = offer[k];
    end

    wr_ptr_d = wr_ptr_q + AW'(wr_num);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(wr_num) - CW'(pop);
    seq_d    = seq_q + 16'(n_off);
    lost_d   = drop;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      seq_q    <= '0;
      lost_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      seq_q    <= seq_d;
      lost_q   <= lost_d;
    end
  end

  // Storage needs no reset; outputs are masked to zero while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  always_comb begin
    trace_valid_o = (count_q != '0);
    head          = trace_valid_o ? mem_q[rd_ptr_q] : '0;
    trace_kind_o  = head.kind;
    trace_pc_o    = head.pc;
    trace_instr_o = head.instr;
    trace_rd_o    = head.rd;
    trace_data_o  = head.data;
    trace_tval_o  = head.tval;
    trace_priv_o  = head.priv;
    trace_seq_o   = head.seq;
    lost_o        = lost_q;
  end

`ifdef COMMIT_TRACE_LOST_CNT_EN
  logic [15:0] lost_cnt_q, lost_cnt_d;
  logic [16:0] lost_sum;

  always_comb begin
    lost_sum   = {1'b0, lost_cnt_q} + 17'(n_off);
    lost_cnt_d = lost_cnt_q;
    if (drop) lost_cnt_d = lost_sum[16] ? 16'hFFFF : lost_sum[15:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) lost_cnt_q <= '0;
    else       lost_cnt_q <= lost_cnt_d;
  end

  assign lost_cnt_o = lost_cnt_q;
`endif

endmodule

// File: tb/tb_commit_trace_sequencer.sv
// Bench for commit_trace_sequencer: directed test-plan steps followed by random traffic,
// every cycle checked against a queue-based record model.
module tb_commit_trace_sequencer;

  localparam int DEPTH = 8;
  localparam int VLEN  = 64;
  localparam int XLEN  = 64;
  localparam int REC_W = 1 + VLEN + 32 + 5 + XLEN + XLEN + 2 + 16;

  logic                 clk = 1'b0;
  logic                 rst_i = 1'b1;
  logic                 enable_i = 1'b0;
  logic [1:0]           commit_valid_i = '0;
  logic [1:0][VLEN-1:0] commit_pc_i = '0;
  logic [1:0][31:0]     commit_instr_i = '0;
  logic [1:0][4:0]      commit_rd_i = '0;
  logic [1:0][XLEN-1:0] commit_wdata_i = '0;
  logic [1:0]           priv_lvl_i = '0;
  logic                 exc_valid_i = 1'b0;
  logic [XLEN-1:0]      exc_cause_i = '0;
  logic [XLEN-1:0]      exc_tval_i = '0;
  logic                 trace_valid_o;
  logic                 trace_ready_i = 1'b0;
  logic                 trace_kind_o;
  logic [VLEN-1:0]      trace_pc_o;
  logic [31:0]          trace_instr_o;
  logic [4:0]           trace_rd_o;
  logic [XLEN-1:0]      trace_data_o;
  logic [XLEN-1:0]      trace_tval_o;
  logic [1:0]           trace_priv_o;
  logic [15:0]          trace_seq_o;
  logic                 lost_o;
`ifdef COMMIT_TRACE_LOST_CNT_EN
  logic [15:0]          lost_cnt_o;
`endif

  commit_trace_sequencer #(.DEPTH(DEPTH), .VLEN(VLEN), .XLEN(XLEN)) dut (
    .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i),
    .commit_valid_i(commit_valid_i), .commit_pc_i(commit_pc_i),
    .commit_instr_i(commit_instr_i), .commit_rd_i(commit_rd_i),
    .commit_wdata_i(commit_wdata_i), .priv_lvl_i(priv_lvl_i),
    .exc_valid_i(exc_valid_i), .exc_cause_i(exc_cause_i), .exc_tval_i(exc_tval_i),
    .trace_valid_o(trace_valid_o), .trace_ready_i(trace_ready_i),
    .trace_kind_o(trace_kind_o), .trace_pc_o(trace_pc_o), .trace_instr_o(trace_instr_o),
    .trace_rd_o(trace_rd_o), .trace_data_o(trace_data_o), .trace_tval_o(trace_tval_o),
    .trace_priv_o(trace_priv_o), .trace_seq_o(trace_seq_o), .lost_o(lost_o)
`ifdef COMMIT_TRACE_LOST_CNT_EN
    , .lost_cnt_o(lost_cnt_o)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard / model ----------------
  logic [REC_W-1:0] exp_q[$];
  int               seq_m = 0;
  logic             exp_lost = 1'b0;
  int               exp_lost_cnt = 0;
  int               checks = 0;
  int               errors = 0;

  function automatic logic [REC_W-1:0] mk_rec(input logic kind, input logic [VLEN-1:0] pc,
      input logic [31:0] instr, input logic [4:0] rd, input logic [XLEN-1:0] data,
      input logic [XLEN-1:0] tval, input logic [1:0] priv, input logic [15:0] seq);
    return {kind, pc, instr, rd, data, tval, priv, seq};
  endfunction

  function automatic logic [REC_W-1:0] obs_rec();
    return {trace_kind_o, trace_pc_o, trace_instr_o, trace_rd_o, trace_data_o,
            trace_tval_o, trace_priv_o, trace_seq_o};
  endfunction

  task automatic chk(input string tag, input logic [REC_W-1:0] obs, input logic [REC_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("valid", REC_W'(trace_valid_o), REC_W'(exp_q.size() != 0));
    if (exp_q.size() != 0) chk("head_rec", obs_rec(), exp_q[0]);
    chk("lost", REC_W'(lost_o), REC_W'(exp_lost));
`ifdef COMMIT_TRACE_LOST_CNT_EN
    chk("lost_cnt", REC_W'(lost_cnt_o), REC_W'(exp_lost_cnt));
`endif
  endtask

  // Applies the sequencing rules to the inputs currently driven, for the coming clock edge.
  task automatic model_step();
    logic [REC_W-1:0] recs[$];
    int occ;
    int n;
    occ = exp_q.size();
    if (enable_i) begin
      for (int p = 0; p < 2; p++)
        if (commit_valid_i[p])
          recs.push_back(mk_rec(1'b0, commit_pc_i[p], commit_instr_i[p], commit_rd_i[p],
                                commit_wdata_i[p], '0, priv_lvl_i, 16'(seq_m + recs.size())));
      if (exc_valid_i)
        recs.push_back(mk_rec(1'b1, commit_pc_i[0], '0, '0, exc_cause_i, exc_tval_i,
                              priv_lvl_i, 16'(seq_m + recs.size())));
    end
    n = recs.size();
    if (occ != 0 && trace_ready_i) void'(exp_q.pop_front());
    exp_lost = 1'b0;
    if (n > DEPTH - occ) begin
      exp_lost = 1'b1;
      exp_lost_cnt = (exp_lost_cnt + n > 65535) ? 65535 : exp_lost_cnt + n;
    end else begin
      foreach (recs[i]) exp_q.push_back(recs[i]);
    end
    seq_m = (seq_m + n) % 65536;
  endtask

  // ---------------- driver tasks ----------------
  task automatic rand_data();
    for (int p = 0; p < 2; p++) begin
      commit_pc_i[p]    = {$urandom(), $urandom()};
      commit_instr_i[p] = $urandom();
      commit_rd_i[p]    = 5'($urandom_range(0, 31));
      commit_wdata_i[p] = {$urandom(), $urandom()};
    end
    priv_lvl_i  = 2'($urandom_range(0, 3));
    exc_cause_i = {$urandom(), $urandom()};
    exc_tval_i  = {$urandom(), $urandom()};
  endtask

  task automatic tick(input logic en, input logic [1:0] cv, input logic ex, input logic rdy);
    enable_i       = en;
    commit_valid_i = cv;
    exc_valid_i    = ex;
    trace_ready_i  = rdy;
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i          = 1'b1;
    enable_i       = 1'b1;
    commit_valid_i = 2'b11;
    exc_valid_i    = 1'($urandom_range(0, 1));
    trace_ready_i  = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    exp_q.delete();
    seq_m        = 0;
    exp_lost     = 1'b0;
    exp_lost_cnt = 0;
    chk("rst_valid", REC_W'(trace_valid_o), '0);
    chk("rst_rec", obs_rec(), '0);
    chk("rst_lost", REC_W'(lost_o), '0);
`ifdef COMMIT_TRACE_LOST_CNT_EN
    chk("rst_lost_cnt", REC_W'(lost_cnt_o), '0);
`endif
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * DEPTH && exp_q.size() != 0; i++) begin
      rand_data();
      tick(1'b0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1);
    end
    tick(1'b0, 2'b00, 1'b0, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    @(posedge clk);
    #1;
    do_reset();

    // Single retirement, then back-to-back two-port traffic.
    rand_data();
    commit_pc_i[0]    = 64'h8000_0000;
    commit_wdata_i[0] = 64'h5;
    tick(1'b1, 2'b01, 1'b0, 1'b1);
    chk("t1_pc", REC_W'(trace_pc_o), REC_W'(64'h8000_0000));
    chk("t1_seq", REC_W'(trace_seq_o), '0);
    chk("t1_kind", REC_W'(trace_kind_o), '0);
    chk("t1_data", REC_W'(trace_data_o), REC_W'(64'h5));
    tick(1'b1, 2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      rand_data();
      tick(1'b1, 2'b11, 1'b0, 1'b1);
    end
    drain();

    // Both ports plus exception in one cycle.
    do_reset();
    rand_data();
    commit_pc_i[0] = 64'h100;
    commit_pc_i[1] = 64'h104;
    exc_cause_i    = 64'h2;
    exc_tval_i     = 64'hDEAD;
    tick(1'b1, 2'b11, 1'b1, 1'b1);
    chk("mix_pc0", REC_W'(trace_pc_o), REC_W'(64'h100));
    chk("mix_seq0", REC_W'(trace_seq_o), '0);
    drain();

    // Backpressure: fill 7, offer 2 (dropped), then 1 more, then full with a pop.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      rand_data();
      tick(1'b1, 2'b11, 1'b0, 1'b0);
    end
    rand_data();
    tick(1'b1, 2'b01, 1'b0, 1'b0);
    rand_data();
    tick(1'b1, 2'b11, 1'b0, 1'b0);
    chk("ovf_lost_pulse", REC_W'(lost_o), REC_W'(1'b1));
    rand_data();
    tick(1'b1, 2'b01, 1'b0, 1'b0);
    chk("ovf_lost_clear", REC_W'(lost_o), '0);
    rand_data();
    tick(1'b1, 2'b01, 1'b0, 1'b1);
    chk("full_pop_lost", REC_W'(lost_o), REC_W'(1'b1));
    drain();

    // Disable with commits still arriving: the buffered four drain, nothing new enters.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      rand_data();
      tick(1'b1, 2'b11, 1'b0, 1'b0);
    end
    for (int i = 0; i < 6; i++) begin
      rand_data();
      tick(1'b0, 2'b11, 1'b1, 1'b1);
    end
    rand_data();
    tick(1'b1, 2'b01, 1'b0, 1'b0);
    chk("dis_seq_hold", REC_W'(trace_seq_o), REC_W'(16'd4));
    drain();

    // Mid-stream reset with five records buffered and the head stalled.
    for (int i = 0; i < 2; i++) begin
      rand_data();
      tick(1'b1, 2'b11, 1'b0, 1'b0);
    end
    rand_data();
    tick(1'b1, 2'b01, 1'b0, 1'b0);
    do_reset();
    rand_data();
    tick(1'b1, 2'b10, 1'b0, 1'b1);
    chk("post_rst_seq", REC_W'(trace_seq_o), '0);
    drain();

    // Random traffic, first with a mostly-ready sink, then a mostly-stalled one.
    for (int i = 0; i < 600; i++) begin
      rand_data();
      tick(1'($urandom_range(0, 9) != 0), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 3) == 0),
           (i < 350) ? 1'($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 3) == 0));
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
